quad_dec_multi: RTL
===================

# quad_dec_multi

Parametrised multi-channel quadrature decoder for trackball/spinner inputs on the JAMMA board; the successor to the single-channel 4-bit quadrature timer. Each channel synchronises and debounces its A/B lines, then decodes steps in x1, x2 or x4 resolution. Each channel accumulates a signed delta count that the host reads and clears. Per-channel direction, sticky illegal-transition and sticky overflow flags are provided to the CPU-side register block.

## Interface
- CH, 2, number of independent quadrature channels (1..8)
- WIDTH, 8, signed delta counter width per channel (4..16)
- FILT, 3, debounce length: a line change is accepted after FILT+1 stable cycles (0..15)
- SAT, 0, 0 = counter wraps, 1 = counter saturates

- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset; all registers cleared while low
- ena  in  1  global count enable
- mode  in  2  00 = x1, 01 = x2, 10/11 = x4 (sampled every cycle, shared by all channels)
- a  in  CH  quadrature phase A per channel (asynchronous)
- b  in  CH  quadrature phase B per channel (asynchronous)
- rd  in  CH  per-channel read-and-clear strobe, one cycle
- q  out  CH*WIDTH  signed delta counts, channel i at bits [i*WIDTH +: WIDTH]
- dir  out  CH  last counted direction, 1 = forward
- err  out  CH  sticky illegal-transition flag
- ovf  out  CH  sticky overflow flag

## Operation
- Synchroniser: 2 flops per line, reset value 0.
- Filter: per line, a run counter of width clog2(FILT+1) increments while the synchronised value differs from the filtered value. The filtered value takes the synchronised value when the counter equals FILT, and the counter then clears. The counter also clears whenever the two values match. Filtered value resets to 0.
- Decoder: prev[1:0] <= {filtA,filtB} every cycle regardless of ena; reset 00.
- Forward sequence: 00 -> 10 -> 11 -> 01 -> 00. Reverse is the opposite order.
- Both bits changing in one cycle is illegal. It produces no count step. It sets err[i] if ena=1.
- Step qualification:
  - x4: every legal transition counts.
  - x2: only transitions where A changes count.
  - x1: only 00->10 (forward, +1) and 10->00 (reverse, -1) count.
- ena=0: no count, dir and err updates; filtering and prev tracking continue.
- Counted step: count += +1 or -1; dir <= 1 on forward, 0 on reverse.
- Wrap (SAT=0): a step from max to min, or from min to max, wraps and sets ovf[i].
- Saturate (SAT=1): a step beyond max or min holds the count and sets ovf[i].
- rd[i]=1: count, err and ovf clear at the next edge. A step in the same cycle is not lost: count loads +1 or -1. A new illegal transition in the same cycle leaves err=1. A new overflow cannot coincide with a clear.
- Channels are fully independent; rd[i] affects only channel i.

## Timing
- Reset values: q=0, dir=0, err=0, ovf=0; synchronisers, filters and prev = 0.
- The A/B input changes before edge k.
- The filtered value updates at edge k+2+FILT.
- q, dir, err and ovf update at edge k+3+FILT.
- Glitches shorter than FILT+1 cycles, measured at the synchroniser output, never reach the decoder.
- Minimum resolvable step spacing is FILT+1 cycles per line change. Faster input is undefined but must not corrupt other channels.
- rd[i] at edge n: q reads 0 (or ±1) after edge n.
- Deasserting reset mid-operation restarts from reset values. A line sitting at 1 is then absorbed as a filter change, producing at most one step or err per channel; benches ignore that first event.

## Test plan
- Reset then run a forward x4 sequence of 8 full cycles (32 transitions) on channel 0, FILT=3, spaced 8 cycles apart -> q0=32 (WIDTH=8), dir0=1, err0=0, q1=0. The first change is visible exactly 6 edges after the input edge.
- Mode sweep: the same 4 forward cycles in x1, x2 and x4 -> q0=4, 8 and 16 respectively. Then 4 reverse cycles in x4 -> q0 returns to 0 and dir0=0.
- Glitch: a 3-cycle pulse on a[0] with FILT=3 -> no change; a 4-cycle pulse -> exactly one +1 followed by one -1.
- Illegal: A and B toggle together 00->11 with ena=1 -> q unchanged, err0=1. The flag persists until rd[0]; with ena=0 the same stimulus leaves err0=0.
- Overflow, WIDTH=4:
  - SAT=0: 8 forward steps from 0 -> q0=-8, ovf0=1.
  - SAT=1: 10 forward steps -> q0=7, ovf0=1.
- Read collision: rd[0] on the same edge as a counted forward step with q0=5 -> q0=1, ovf0 and err0 cleared. rd[1] issued simultaneously leaves channel 0 unaffected.

Source files
------------

// File: rtl/quad_dec_multi_if.sv
// rtl/quad_dec_multi_if.sv - host-side bundle for the multi-channel quadrature decoder
interface quad_dec_multi_if #(
    parameter int CH    = 2,
    parameter int WIDTH = 8
);
    logic                  ena;
    logic [1:0]            mode;
    logic [CH-1:0]         a;
    logic [CH-1:0]         b;
    logic [CH-1:0]         rd;
    logic [CH*WIDTH-1:0]   q;
    logic [CH-1:0]         dir;
    logic [CH-1:0]         err;
    logic [CH-1:0]         ovf;

    modport master (
        output ena, mode, a, b, rd,
        input  q, dir, err, ovf
    );

    modport slave (
        input  ena, mode, a, b, rd,
        output q, dir, err, ovf
    );
endinterface

// File: rtl/quad_dec_multi.sv
// rtl/quad_dec_multi.sv - multi-channel quadrature decoder with debounced inputs and signed delta counters
module quad_dec_multi #(
    parameter int CH    = 2,
    parameter int WIDTH = 8,
    parameter int FILT  = 3,
    parameter int SAT   = 0
) (
    input  logic            clk,
    input  logic            reset,
    quad_dec_multi_if.slave bus
);
    // Run counter must hold FILT; FILT=0 still needs a one-bit counter.
    localparam int              CW      = (FILT < 1) ? 1 : $clog2(FILT + 1);
    localparam logic [CW-1:0]   RUN_END = CW'(FILT);
    localparam logic [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_NEG = {WIDTH{1'b1}};

    logic [CH*WIDTH-1:0] q_all;
    logic [CH-1:0]       dir_all;
    logic [CH-1:0]       err_all;
    logic [CH-1:0]       ovf_all;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        // Line pairs are packed {A,B}: bit 1 is phase A, bit 0 is phase B.
        logic [1:0]         sync1_q, sync1_d;
        logic [1:0]         sync2_q, sync2_d;
        logic [1:0]         filt_q,  filt_d;
        logic [1:0][CW-1:0] run_q,   run_d;
        logic [1:0]         prev_q,  prev_d;
        logic [WIDTH-1:0]   cnt_q,   cnt_d;
        logic               dir_q,   dir_d;
        logic               err_q,   err_d;
        logic               ovf_q,   ovf_d;

        logic [1:0] chg;
        logic       fwd;
        logic       single;
        logic       illegal;
        logic       qual;
        logic       step;
        logic       at_limit;

        // Two-stage synchroniser on the asynchronous A/B pins.
        always_comb begin
            sync1_d = {bus.a[i], bus.b[i]};
            sync2_d = sync1_q;
        end

        // Debounce: a line is accepted once it has differed for FILT+1 cycles.
        always_comb begin
            filt_d = filt_q;
            run_d  = '0;
            for (int l = 0; l < 2; l++) begin
                if (sync2_q[l] != filt_q[l]) begin
                    if (run_q[l] == RUN_END) begin
                        filt_d[l] = sync2_q[l];
                    end else begin
                        run_d[l] = run_q[l] + CW'(1);
                    end
                end
            end
        end

        // Transition classification between the previous and current filtered state.
        always_comb begin
            prev_d  = filt_q;
            chg     = filt_q ^ prev_q;
            single  = chg[1] ^ chg[0];
            illegal = chg[1] & chg[0];
            fwd     = ((prev_q == 2'b00) && (filt_q == 2'b10)) ||
                      ((prev_q == 2'b10) && (filt_q == 2'b11)) ||
                      ((prev_q == 2'b11) && (filt_q == 2'b01)) ||
                      ((prev_q == 2'b01) && (filt_q == 2'b00));
            case (bus.mode)
                2'b00:   qual = ((prev_q == 2'b00) && (filt_q == 2'b10)) ||
                                ((prev_q == 2'b10) && (filt_q == 2'b00));
                2'b01:   qual = single & chg[1];
                default: qual = single;
            endcase
            step = bus.ena & qual;
        end

        // Delta counter, direction and sticky flags; a read clears but keeps a same-cycle step.
        always_comb begin
            cnt_d    = cnt_q;
            dir_d    = dir_q;
            err_d    = err_q;
            ovf_d    = ovf_q;
            at_limit = fwd ? (cnt_q == CNT_MAX) : (cnt_q == CNT_MIN);
            if (bus.rd[i]) begin
                cnt_d = step ? (fwd ? CNT_ONE : CNT_NEG) : '0;
                err_d = bus.ena & illegal;
                ovf_d = 1'b0;
            end else begin
                if (bus.ena && illegal) begin
                    err_d = 1'b1;
                end
                if (step) begin
                    if (at_limit) begin
                        ovf_d = 1'b1;
                        if (SAT == 0) begin
                            cnt_d = fwd ? CNT_MIN : CNT_MAX;
                        end
                    end else begin
                        cnt_d = fwd ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
                    end
                end
            end
            if (step) begin
                dir_d = fwd;
            end
        end

        // Per-channel state registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q <= '0;
                sync2_q <= '0;
                filt_q  <= '0;
                run_q   <= '0;
                prev_q  <= '0;
                cnt_q   <= '0;
                dir_q   <= 1'b0;
                err_q   <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                filt_q  <= filt_d;
                run_q   <= run_d;
                prev_q  <= prev_d;
                cnt_q   <= cnt_d;
                dir_q   <= dir_d;
                err_q   <= err_d;
                ovf_q   <= ovf_d;
            end
        end

        assign q_all[i*WIDTH +: WIDTH] = cnt_q;
        assign dir_all[i]              = dir_q;
        assign err_all[i]              = err_q;
        assign ovf_all[i]              = ovf_q;
    end

    assign bus.q   = q_all;
    assign bus.dir = dir_all;
    assign bus.err = err_all;
    assign bus.ovf = ovf_all;
endmodule
